// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-dump reader: width defaults and FSM state codes.
package reg_dump_reader_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ISSUE   = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_HOLD    = 3'd3;
  localparam state_t ST_FINISH  = 3'd4;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Register-file read port plus the valid/ready word stream leaving the dump reader.
interface reg_dump_reader_if
  import reg_dump_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] rf_ra;
  logic [DATA_W-1:0] rf_a;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_idx;
  logic [DATA_W-1:0] out_data;

  modport master (
    output rf_ra,
    input  rf_a,
    output out_valid,
    input  out_ready,
    output out_idx,
    output out_data
  );

  modport slave (
    input  rf_ra,
    output rf_a,
    input  out_valid,
    output out_ready,
    input  out_idx,
    input  out_data
  );

endinterface

// File: rtl/reg_dump_index_ctr.sv
// Current register index for a dump: loads the bounds, steps with natural wrap,
// and flags when the final index is reached.
module reg_dump_index_ctr
  import reg_dump_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_idx,
  input  logic [ADDR_W-1:0] load_last,
  output logic [ADDR_W-1:0] cur_idx,
  output logic [ADDR_W-1:0] next_idx,
  output logic              is_last
);

  logic [ADDR_W-1:0] cur_idx_q, cur_idx_d;
  logic [ADDR_W-1:0] last_idx_q, last_idx_d;

  always_comb begin
    cur_idx_d  = cur_idx_q;
    last_idx_d = last_idx_q;
    if (load) begin
      cur_idx_d  = load_idx;
      last_idx_d = load_last;
    end else if (inc) begin
      cur_idx_d  = next_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_idx_q  <= '0;
      last_idx_q <= '0;
    end else begin
      cur_idx_q  <= cur_idx_d;
      last_idx_q <= last_idx_d;
    end
  end

  // Wrap past the top register falls out of the fixed index width.
  assign next_idx = cur_idx_q + ADDR_W'(1);
  assign cur_idx  = cur_idx_q;
  assign is_last  = (cur_idx_q == last_idx_q);

endmodule

// File: rtl/reg_dump_reader.sv
// Streams a wrapping range of register-file words out through a valid/ready port,
// one issue/capture/hold round per word.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  output logic              busy,
  output logic              done,
  reg_dump_reader_if.master bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rf_ra_q, rf_ra_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              ctr_load;
  logic              ctr_inc;
  logic [ADDR_W-1:0] cur_idx;
  logic [ADDR_W-1:0] next_idx;
  logic              is_last;

  reg_dump_index_ctr #(.ADDR_W(ADDR_W)) u_idx_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (ctr_load),
    .inc       (ctr_inc),
    .load_idx  (first_idx),
    .load_last (last_idx),
    .cur_idx   (cur_idx),
    .next_idx  (next_idx),
    .is_last   (is_last)
  );

  // rf_ra only moves on the edge that leaves IDLE or HOLD, so it is stable across ISSUE.
  always_comb begin
    state_d     = state_q;
    rf_ra_d     = rf_ra_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    ctr_load    = 1'b0;
    ctr_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ctr_load = 1'b1;
          rf_ra_d  = first_idx;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        out_data_d  = bus.rf_a;
        out_idx_d   = cur_idx;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (is_last) begin
            state_d = ST_FINISH;
          end else begin
            ctr_inc = 1'b1;
            rf_ra_d = next_idx;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rf_ra_q     <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rf_ra_q     <= rf_ra_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_FINISH);
  assign bus.rf_ra     = rf_ra_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_data  = out_data_q;

endmodule
